// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: state encodings,
// fault cause codes, the nop encoding and a small alignment helper.
`timescale 1ns/1ps
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_VALID = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_e;

  localparam logic [1:0]  CAUSE_NONE     = 2'd0;
  localparam logic [1:0]  CAUSE_BUS_ERR  = 2'd1;
  localparam logic [1:0]  CAUSE_MISALIGN = 2'd2;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one bus read at a time, a single held entry for
// the decoder, redirects that never abandon a started read.
// Optional feature macro: FETCH_ALIGN_CHECK_EN -- when defined, a redirect
// to a non-word-aligned PC becomes a misaligned fault entry without any bus
// read; when undefined, the bus address low bits are simply forced to zero.
`timescale 1ns/1ps
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        I_clk,
  input  logic        I_reset,
  output logic        O_bus_req,
  output logic [31:0] O_bus_addr,
  input  logic        I_bus_ack,
  input  logic        I_bus_err,
  input  logic [31:0] I_bus_data,
  output logic        O_valid,
  input  logic        I_ready,
  output logic [31:0] O_instr,
  output logic [31:0] O_pc,
  output logic        O_fault,
  output logic [1:0]  O_fault_cause,
  input  logic        I_redirect,
  input  logic [31:0] I_redirect_pc
);

`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic ALIGN_CHECK = 1'b1;
`else
  localparam logic ALIGN_CHECK = 1'b0;
`endif

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic         kill_q;
  logic [31:0]  kill_pc_q;
  logic         started_q;   // low only for the first edge after reset release
  logic [31:0]  instr_q;
  logic [31:0]  opc_q;
  logic         fault_q;
  logic [1:0]   cause_q;

  logic         bus_done;
  logic         redir_go;
  logic [31:0]  redir_tgt;
  logic         tgt_misaligned;

  assign bus_done = started_q && (I_bus_ack || I_bus_err);

  // Decide whether the PC is retargeted this cycle, and to where. In S_WAIT a
  // redirect only takes effect once the in-flight read finishes; a redirect
  // arriving together with the response wins over an older latched target.
  always_comb begin
    redir_go  = 1'b0;
    redir_tgt = I_redirect_pc;
    case (state_q)
      S_WAIT: begin
        if (!started_q) begin
          redir_go = I_redirect;
        end else if (bus_done && (kill_q || I_redirect)) begin
          redir_go = 1'b1;
          if (!I_redirect) redir_tgt = kill_pc_q;
        end
      end
      S_VALID, S_HALT: redir_go = I_redirect;
      default: redir_go = 1'b0;
    endcase
    tgt_misaligned = ALIGN_CHECK && is_misaligned(redir_tgt);
  end

  // Fetch FSM with registered entry fields.
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state_q   <= S_WAIT;
      pc_q      <= RESET_PC;
      kill_q    <= 1'b0;
      kill_pc_q <= RESET_PC;
      started_q <= 1'b0;
      instr_q   <= NOP_INSTR;
      opc_q     <= RESET_PC;
      fault_q   <= 1'b0;
      cause_q   <= CAUSE_NONE;
    end else begin
      started_q <= 1'b1;
      if (redir_go) begin
        kill_q <= 1'b0;
        pc_q   <= redir_tgt;
        if (tgt_misaligned) begin
          state_q <= S_VALID;
          fault_q <= 1'b1;
          cause_q <= CAUSE_MISALIGN;
          instr_q <= NOP_INSTR;
          opc_q   <= redir_tgt;
        end else begin
          state_q <= S_WAIT;
        end
      end else begin
        case (state_q)
          S_WAIT: begin
            if (started_q && I_bus_ack) begin
              instr_q <= I_bus_data;
              opc_q   <= pc_q;
              fault_q <= 1'b0;
              cause_q <= CAUSE_NONE;
              state_q <= S_VALID;
            end else if (started_q && I_bus_err) begin
              instr_q <= NOP_INSTR;
              opc_q   <= pc_q;
              fault_q <= 1'b1;
              cause_q <= CAUSE_BUS_ERR;
              state_q <= S_VALID;
            end else if (I_redirect) begin
              kill_q    <= 1'b1;
              kill_pc_q <= I_redirect_pc;
            end
          end
          S_VALID: begin
            if (I_ready) begin
              if (fault_q) begin
                state_q <= S_HALT;
              end else begin
                pc_q    <= pc_q + 32'd4;
                state_q <= S_WAIT;
              end
            end
          end
          S_HALT: state_q <= S_HALT;
          default: state_q <= S_WAIT;
        endcase
      end
    end
  end

  assign O_bus_req     = started_q && (state_q == S_WAIT);
  assign O_valid       = (state_q == S_VALID);
  assign O_instr       = instr_q;
  assign O_pc          = opc_q;
  assign O_fault       = fault_q;
  assign O_fault_cause = cause_q;

`ifdef FETCH_ALIGN_CHECK_EN
  assign O_bus_addr = pc_q;
`else
  assign O_bus_addr = {pc_q[31:2], 2'b00};
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios followed by a randomized run
// against a transaction-level model of the fetch stream.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        ack, err;
  logic [31:0] rdata;
  logic        valid, ready;
  logic [31:0] instr, pc;
  logic        fault;
  logic [1:0]  cause;
  logic        redirect;
  logic [31:0] rpc;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .I_clk(clk), .I_reset(rst),
    .O_bus_req(req), .O_bus_addr(addr),
    .I_bus_ack(ack), .I_bus_err(err), .I_bus_data(rdata),
    .O_valid(valid), .I_ready(ready),
    .O_instr(instr), .O_pc(pc),
    .O_fault(fault), .O_fault_cause(cause),
    .I_redirect(redirect), .I_redirect_pc(rpc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic idle_inputs();
    ack = 1'b0; err = 1'b0; redirect = 1'b0; ready = 1'b0;
    rdata = 32'h0; rpc = 32'h0;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!req && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req !== 1'b1) begin
      errors++;
      $display("FAIL %s: bus_req not seen within 20 cycles", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", valid); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", req); end
    checks++; if (instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h want %h", instr, NOP); end
    checks++; if (pc !== RPC) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, RPC); end
    checks++; if (fault !== 1'b0 || cause !== 2'd0) begin errors++; $display("FAIL reset_fault: got %0b/%0d want 0/0", fault, cause); end
    rst = 1'b0;
  endtask

  task automatic test_first_fetch();
    @(negedge clk);
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL first_req_edge: got %0b want 1", req); end
    wait_req("first_req");
    checks++; if (addr !== RPC) begin errors++; $display("FAIL first_addr: got %h want %h", addr, RPC); end
    repeat (2) @(negedge clk);
    checks++; if (req !== 1'b1 || addr !== RPC) begin errors++; $display("FAIL first_hold: got %0b/%h want 1/%h", req, addr, RPC); end
    ack = 1'b1; rdata = 32'h0050_0093;
    @(negedge clk);
    ack = 1'b0;
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %0b want 1", valid); end
    checks++; if (instr !== 32'h0050_0093) begin errors++; $display("FAIL first_instr: got %h want 00500093", instr); end
    checks++; if (pc !== RPC) begin errors++; $display("FAIL first_pc: got %h want %h", pc, RPC); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (valid !== 1'b1 || instr !== 32'h0050_0093 || pc !== RPC || req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: got v=%0b i=%h pc=%h req=%0b want 1/00500093/%h/0", valid, instr, pc, req, RPC);
      end
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL stall_accept_valid: got %0b want 0", valid); end
    checks++; if (req !== 1'b1 || addr !== 32'h104) begin errors++; $display("FAIL stall_next_req: got %0b/%h want 1/00000104", req, addr); end
  endtask

  task automatic test_redirect_kill();
    redirect = 1'b1; rpc = 32'h200;
    @(negedge clk);
    redirect = 1'b0;
    checks++; if (req !== 1'b1 || addr !== 32'h104) begin errors++; $display("FAIL kill_hold_addr: got %0b/%h want 1/00000104", req, addr); end
    ack = 1'b1; rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    ack = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL kill_discard: got valid=%0b instr=%h want valid 0", valid, instr); end
    checks++; if (req !== 1'b1 || addr !== 32'h200) begin errors++; $display("FAIL kill_new_req: got %0b/%h want 1/00000200", req, addr); end
    ack = 1'b1; rdata = 32'h1111_1111;
    @(negedge clk);
    ack = 1'b0;
    checks++; if (valid !== 1'b1 || instr !== 32'h1111_1111 || pc !== 32'h200) begin
      errors++; $display("FAIL kill_entry: got %0b/%h/%h want 1/11111111/00000200", valid, instr, pc);
    end
  endtask

  task automatic test_bus_error();
    redirect = 1'b1; rpc = 32'h108;
    @(negedge clk);
    redirect = 1'b0;
    checks++; if (req !== 1'b1 || addr !== 32'h108) begin errors++; $display("FAIL err_req: got %0b/%h want 1/00000108", req, addr); end
    err = 1'b1;
    @(negedge clk);
    err = 1'b0;
    checks++; if (valid !== 1'b1 || fault !== 1'b1 || cause !== 2'd1) begin errors++; $display("FAIL err_fault: got %0b/%0b/%0d want 1/1/1", valid, fault, cause); end
    checks++; if (instr !== NOP || pc !== 32'h108) begin errors++; $display("FAIL err_entry: got %h/%h want %h/00000108", instr, pc, NOP); end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (req !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL halt_idle: got req=%0b valid=%0b want 0/0", req, valid); end
      ack = (i == 1); rdata = 32'h7777_7777;
      @(negedge clk);
      ack = 1'b0;
    end
    redirect = 1'b1; rpc = 32'h300;
    @(negedge clk);
    redirect = 1'b0;
    checks++; if (req !== 1'b1 || addr !== 32'h300) begin errors++; $display("FAIL halt_exit: got %0b/%h want 1/00000300", req, addr); end
    ack = 1'b1; rdata = 32'h3333_3333;
    @(negedge clk);
    ack = 1'b0;
    checks++; if (valid !== 1'b1 || pc !== 32'h300 || instr !== 32'h3333_3333 || fault !== 1'b0) begin
      errors++; $display("FAIL halt_exit_entry: got %0b/%h/%h/%0b want 1/00000300/33333333/0", valid, pc, instr, fault);
    end
  endtask

  task automatic test_misaligned();
    redirect = 1'b1; rpc = 32'h202;
    @(negedge clk);
    redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL mis_no_req: got %0b want 0", req); end
    checks++; if (valid !== 1'b1 || fault !== 1'b1 || cause !== 2'd2 || pc !== 32'h202) begin
      errors++; $display("FAIL mis_fault: got %0b/%0b/%0d/%h want 1/1/2/00000202", valid, fault, cause, pc);
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++; if (valid !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL mis_halt: got %0b/%0b want 0/0", valid, req); end
    redirect = 1'b1; rpc = 32'h400;
    @(negedge clk);
    redirect = 1'b0;
`else
    checks++; if (req !== 1'b1 || addr !== 32'h200) begin errors++; $display("FAIL mis_forced_addr: got %0b/%h want 1/00000200", req, addr); end
    ack = 1'b1; rdata = 32'h2222_2222;
    @(negedge clk);
    ack = 1'b0;
    checks++; if (valid !== 1'b1 || fault !== 1'b0 || cause !== 2'd0) begin
      errors++; $display("FAIL mis_no_fault: got %0b/%0b/%0d want 1/0/0", valid, fault, cause);
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
`endif
  endtask

  task automatic test_reset_mid_wait();
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL midrst_pre: got req=%0b want 1", req); end
    #2 rst = 1'b1;
    #1;
    checks++; if (valid !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: got %0b/%0b want 0/0", valid, req); end
    checks++; if (pc !== RPC || instr !== NOP || fault !== 1'b0 || cause !== 2'd0) begin
      errors++; $display("FAIL midrst_regs: got %h/%h/%0b/%0d want %h/%h/0/0", pc, instr, fault, cause, RPC, NOP);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req !== 1'b1 || addr !== RPC) begin errors++; $display("FAIL midrst_release: got %0b/%h want 1/%h", req, addr, RPC); end
  endtask

  // Randomized run: bench acts as bus slave; model tracks the expected PC
  // stream, the held entry and whether the fetcher should be halted.
  task automatic test_random();
    logic [31:0] exp_pc = RPC;
    logic [31:0] rd_addr = 32'h0;
    logic [31:0] e_pc = 32'h0, e_instr = 32'h0, tgt;
    logic        e_fault = 1'b0;
    logic        entry_exp = 1'b0, halted = 1'b0, active = 1'b0, discard = 1'b0;
    logic        r, junk_ok;
    int          lat = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (entry_exp) begin
        checks++;
        if (valid !== 1'b1 || pc !== e_pc || instr !== e_instr || fault !== e_fault || cause !== (e_fault ? 2'd1 : 2'd0)) begin
          errors++;
          $display("FAIL rnd_entry: got v=%0b pc=%h i=%h f=%0b c=%0d want 1/%h/%h/%0b", valid, pc, instr, fault, cause, e_pc, e_instr, e_fault);
        end
      end else begin
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rnd_valid: got %0b want 0 at cycle %0d", valid, cyc); end
      end
      if (halted) begin
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL rnd_halt_req: got %0b want 0", req); end
      end else if (!entry_exp) begin
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL rnd_wait_req: got %0b want 1 at cycle %0d", req, cyc); end
      end
      if (active && req) begin
        checks++; if (addr !== rd_addr) begin errors++; $display("FAIL rnd_addr_hold: got %h want %h", addr, rd_addr); end
      end
      idle_inputs();
      junk_ok = (entry_exp || halted) && !active;
      if (!entry_exp && !halted && !active && req) begin
        active = 1'b1;
        rd_addr = exp_pc;
        lat = $urandom_range(0, 3);
        checks++; if (addr !== exp_pc) begin errors++; $display("FAIL rnd_addr: got %h want %h", addr, exp_pc); end
      end
      r = halted ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      if (r) begin
        tgt = $urandom & 32'hFFFF_FFFC;
        redirect = 1'b1; rpc = tgt;
        exp_pc = tgt;
        entry_exp = 1'b0;
        halted = 1'b0;
        if (active) discard = 1'b1;
      end else if (entry_exp && $urandom_range(0, 1) == 1) begin
        ready = 1'b1;
        entry_exp = 1'b0;
        if (e_fault) halted = 1'b1;
        else exp_pc = e_pc + 32'd4;
      end
      if (junk_ok && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1) ack = 1'b1; else err = 1'b1;
        rdata = $urandom;
      end
      if (active) begin
        if (lat == 0) begin
          active = 1'b0;
          if ($urandom_range(0, 7) == 0) err = 1'b1;
          else begin ack = 1'b1; rdata = mem_word(rd_addr); end
          if (discard) discard = 1'b0;
          else begin
            entry_exp = 1'b1;
            e_pc = rd_addr;
            e_fault = err;
            e_instr = err ? NOP : mem_word(rd_addr);
          end
        end else begin
          lat--;
        end
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect_kill();
    test_bus_error();
    test_misaligned();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have ports: I_clk in 1, clock; I_reset in 1, async active-high reset (one clock; reset asynchronous, active-high).
REQ-003 SHALL have ports: O_bus_req out 1, fetch request; O_bus_addr out 32, word address; I_bus_ack in 1, read done; I_bus_err in 1, read failed; I_bus_data in 32, read data.
REQ-004 SHALL have ports: O_valid out 1, instruction available; I_ready in 1, decoder/exec accepts; O_instr out 32, instruction word to decoder; O_pc out 32, its address.
REQ-005 SHALL have ports: O_fault out 1, entry is a fault; O_fault_cause out 2, 0=none, 1=bus error, 2=misaligned.
REQ-006 SHALL have ports: I_redirect in 1, taken branch/jump/trap; I_redirect_pc in 32, new PC.

Function
REQ-007 SHALL implement states S_WAIT (O_bus_req=1), S_VALID (O_valid=1), S_HALT (idle, O_valid=0, O_bus_req=0).
REQ-008 SHALL hold O_bus_req and O_bus_addr stable in S_WAIT until I_bus_ack or I_bus_err; never abandon a started bus read.
REQ-009 SHALL on I_bus_ack in S_WAIT with no kill pending register I_bus_data to O_instr and enter S_VALID; O_valid rises the next cycle (1-cycle capture latency).
REQ-010 SHALL on I_bus_err in S_WAIT with no kill pending enter S_VALID with O_fault=1, cause 1, O_instr=32'h0000_0013 (nop).
REQ-011 SHALL on O_valid&I_ready of a non-fault entry set PC=PC+4 (mod 2^32) and enter S_WAIT; O_bus_req asserts the next cycle.
REQ-012 SHALL on O_valid&I_ready of a fault entry enter S_HALT; only I_redirect leaves S_HALT.
REQ-013 SHALL give I_redirect priority over I_ready: in S_VALID or S_HALT, drop the held entry, set PC=I_redirect_pc, enter S_WAIT next cycle.
REQ-014 SHALL on I_redirect in S_WAIT set a kill flag and latch I_redirect_pc; the in-flight response (ack or err) is discarded, then a new request to the latched PC issues the following cycle.
REQ-015 SHALL let the last of several redirects during one bus read win.
REQ-016 SHALL treat I_redirect in the same cycle as I_bus_ack/I_bus_err as REQ-014 (response discarded).
REQ-017 SHALL ignore I_bus_ack/I_bus_err outside S_WAIT.
REQ-018 SHALL keep O_instr, O_pc, O_fault stable while O_valid=1 and no redirect.

Reset
REQ-019 SHALL on I_reset asynchronously force: state S_WAIT, PC=RESET_PC, kill=0, O_valid=0, O_instr=32'h0000_0013, O_fault=0, O_fault_cause=0, O_pc=RESET_PC.
REQ-020 SHALL assert O_bus_req in the first clock edge after I_reset deasserts; a bus response pending across reset is the bus's responsibility and is ignored via REQ-017 semantics only if outside S_WAIT.

Configuration
REQ-021 SHALL, with FETCH_ALIGN_CHECK_EN defined, turn a redirect with I_redirect_pc[1:0]!=0 into S_VALID with O_fault=1, cause 2, O_pc=I_redirect_pc, no bus read.
REQ-022 SHALL, without FETCH_ALIGN_CHECK_EN, force O_bus_addr[1:0]=2'b00 and never raise cause 2.

Structure
REQ-023 SHALL place fetch state encodings and fault cause codes in shared header cpu/cpudefs.vh; nop encoding in cpu/riscvdefs.vh.
REQ-024 SHALL be a single module, no sub-modules; O_instr feeds decoder I_instr, O_valid&I_ready drives decoder I_en.

Verification
REQ-025 Reset, RESET_PC=32'h100, ack after 2 cycles with 32'h00500093 -> O_bus_addr=32'h100, O_valid next cycle, O_instr=32'h00500093, O_pc=32'h100.
REQ-026 Hold I_ready=0 for 5 cycles -> O_valid, O_instr, O_pc stable, O_bus_req=0; I_ready=1 -> next request to 32'h104.
REQ-027 I_redirect to 32'h200 while S_WAIT at 32'h104, ack with 32'hDEADBEEF -> data discarded, next request 32'h200, O_valid never shows DEADBEEF.
REQ-028 I_bus_err at 32'h108 -> O_fault=1, cause 1, O_instr=32'h13; after accept O_bus_req=0 until redirect to 32'h300.
REQ-029 FETCH_ALIGN_CHECK_EN defined, redirect to 32'h202 -> no bus request, O_fault=1, cause 2, O_pc=32'h202.
REQ-030 I_reset asserted mid S_WAIT -> outputs at reset values immediately, request to RESET_PC after release.
